// File: rtl/lbp_pkg.sv
// Shared definitions for the streaming LBP engine: FSM states,
// neighbour bit positions inside the 8-bit code, and the border code.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } lbp_state_e;

    // Bit position of each neighbour in the LBP code.
    localparam int unsigned NB_TL = 0;
    localparam int unsigned NB_T  = 1;
    localparam int unsigned NB_TR = 2;
    localparam int unsigned NB_L  = 3;
    localparam int unsigned NB_R  = 4;
    localparam int unsigned NB_BL = 5;
    localparam int unsigned NB_B  = 6;
    localparam int unsigned NB_BR = 7;

    // Code written for every pixel on the frame border.
    localparam logic [7:0] BORDER_CODE = 8'h00;

endpackage

// File: rtl/lbp_window.sv
// Raster-order pixel position counters, two line buffers (rows r-2, r-1)
// and the 3x3 neighbourhood. The window output already includes the
// column being accepted this cycle, so the code can be registered on the
// accepting edge.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_acc,
    input  logic [DW-1:0]   i_data,
    output logic [RW-1:0]   o_row,
    output logic [CW-1:0]   o_col,
    output logic [9*DW-1:0] o_win
);

    logic [DW-1:0] r_lb_top [IMG_W];
    logic [DW-1:0] r_lb_mid [IMG_W];
    logic [2:0][DW-1:0] r_col_a;
    logic [2:0][DW-1:0] r_col_b;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    logic [DW-1:0] w_top;
    logic [DW-1:0] w_mid;
    logic [2:0][DW-1:0] w_col_c;

    assign w_top   = r_lb_top[r_col];
    assign w_mid   = r_lb_mid[r_col];
    assign w_col_c = {i_data, w_mid, w_top};
    assign o_row   = r_row;
    assign o_col   = r_col;

    // Position of the next pixel to accept; wraps to 0 after the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_acc) begin
            r_col <= r_col + CW'(1);
            if (&r_col) begin
                r_row <= r_row + RW'(1);
            end
        end
    end

    // Rotate the line buffers and shift the window by one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (i_acc) begin
            r_lb_top[r_col] <= w_mid;
            r_lb_mid[r_col] <= i_data;
            r_col_a         <= r_col_b;
            r_col_b         <= w_col_c;
        end
    end

    // Flatten the window row-major: index 0 is top-left, 4 is the centre.
    always_comb begin
        o_win = '0;
        for (int rr = 0; rr < 3; rr++) begin
            o_win[(rr*3+0)*DW +: DW] = r_col_a[rr];
            o_win[(rr*3+1)*DW +: DW] = r_col_b[rr];
            o_win[(rr*3+2)*DW +: DW] = w_col_c[rr];
        end
    end

endmodule

// File: rtl/lbp_stream.sv
// Streaming 3x3 LBP engine: fetches a frame in raster order, computes the
// code of the pixel one row up and one column left of each accepted pixel,
// and flushes the last (all-border) row after the input ends.
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [DW-1:0] thr,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic          gray_ready,
    input  logic [DW-1:0] gray_data,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic [7:0]    lbp_data,
    output logic          busy,
    output logic          finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H-1);

    lbp_state_e r_state;
    lbp_state_e w_next;

    logic          r_mode;
    logic [DW-1:0] r_thr;
    logic [CW-1:0] r_fcol;

    logic            w_acc;
    logic            w_clr;
    logic            w_last_px;
    logic            w_border;
    logic [RW-1:0]   w_row;
    logic [RW-1:0]   w_prev_row;
    logic [CW-1:0]   w_col;
    logic [CW-1:0]   w_prev_col;
    logic [9*DW-1:0] w_win;
    logic [DW-1:0]   w_thr_eff;
    logic [7:0]      w_code;

    // g_p >= g_c + thr in DW+1 bits; an out-of-range sum can never be met.
    function automatic logic nb_ge(input logic [DW-1:0] gp,
                                   input logic [DW-1:0] gc,
                                   input logic [DW-1:0] th);
        logic [DW:0] ref_v;
        ref_v = {1'b0, gc} + {1'b0, th};
        return ({1'b0, gp} >= ref_v);
    endfunction

    function automatic logic [7:0] lbp_code(input logic [9*DW-1:0] win,
                                            input logic [DW-1:0]   th);
        logic [DW-1:0] gc;
        logic [7:0]    code;
        gc          = win[4*DW +: DW];
        code        = BORDER_CODE;
        code[NB_TL] = nb_ge(win[0*DW +: DW], gc, th);
        code[NB_T]  = nb_ge(win[1*DW +: DW], gc, th);
        code[NB_TR] = nb_ge(win[2*DW +: DW], gc, th);
        code[NB_L]  = nb_ge(win[3*DW +: DW], gc, th);
        code[NB_R]  = nb_ge(win[5*DW +: DW], gc, th);
        code[NB_BL] = nb_ge(win[6*DW +: DW], gc, th);
        code[NB_B]  = nb_ge(win[7*DW +: DW], gc, th);
        code[NB_BR] = nb_ge(win[8*DW +: DW], gc, th);
        return code;
    endfunction

    lbp_window #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DW    (DW)
    ) u_window (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_clr),
        .i_acc  (w_acc),
        .i_data (gray_data),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_win  (w_win)
    );

    assign w_acc      = (r_state == READ) & gray_ready;
    assign w_clr      = (r_state == IDLE) & start;
    assign w_last_px  = (&w_row) & (&w_col);
    assign gray_addr  = {w_row, w_col};
    assign w_prev_row = w_row - RW'(1);
    assign w_prev_col = w_col - CW'(1);
    // Emitted pixel is (r-1, c-1): border when r-1 = 0, c-1 = 0 or c = 0 (col W-1).
    assign w_border   = (w_row[RW-1:1] == '0) | (w_col[CW-1:1] == '0);
    assign w_thr_eff  = r_mode ? r_thr : '0;
    assign w_code     = lbp_code(w_win, w_thr_eff);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded handshake/status outputs.
    always_comb begin
        w_next   = r_state;
        gray_req = 1'b0;
        busy     = 1'b1;
        finish   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = READ;
            end
            READ: begin
                gray_req = 1'b1;
                if (w_acc && w_last_px) w_next = FLUSH;
            end
            FLUSH: begin
                if (&r_fcol) w_next = DONE;
            end
            DONE: begin
                finish = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Frame configuration captured on an accepted start.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mode <= mode;
            r_thr  <= thr;
        end
    end

    // Column counter for the flushed last row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fcol <= '0;
        end else if (r_state == IDLE) begin
            r_fcol <= '0;
        end else if (r_state == FLUSH) begin
            r_fcol <= r_fcol + CW'(1);
        end
    end

    // Write port: one strobe per accepted pixel from row 1 on, then the flush row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
        end else begin
            lbp_valid <= 1'b0;
            if (w_acc && (w_row != '0)) begin
                lbp_valid <= 1'b1;
                lbp_addr  <= {w_prev_row, w_prev_col};
                lbp_data  <= w_border ? BORDER_CODE : w_code;
            end else if (r_state == FLUSH) begin
                lbp_valid <= 1'b1;
                lbp_addr  <= {LAST_ROW, r_fcol};
                lbp_data  <= BORDER_CODE;
            end
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
// Bench for lbp_stream on an 8x4 frame: a memory-style responder with
// random stalls feeds pixels, and every write is compared with codes and
// an address order computed directly from the frame contents.
module tb_lbp_stream;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int AWT = $clog2(N);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [7:0]     thr = 8'h00;
    logic           gray_ready = 1'b0;
    logic [7:0]     gray_data = 8'h00;
    logic [AWT-1:0] gray_addr;
    logic           gray_req;
    logic [AWT-1:0] lbp_addr;
    logic           lbp_valid;
    logic [7:0]     lbp_data;
    logic           busy;
    logic           finish;

    lbp_stream #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .thr        (thr),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .busy       (busy),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int img [N];
    int got [N];
    int first_addr [4];
    int exp_seq [$];
    int m_mode = 0;
    int m_thr = 0;
    int wi = 0;
    int acc_cnt = 0;
    int fin_cnt = 0;
    int stall_pct = 0;
    bit pend = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected code straight from the neighbourhood definition.
    function automatic int model_code(input int a);
        int r, c, lim, code;
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        r = a / W;
        c = a % W;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        lim  = img[a] + (m_mode != 0 ? m_thr : 0);
        code = 0;
        for (int b = 0; b < 8; b++) begin
            if (img[(r + dr[b]) * W + c + dc[b]] >= lim) code += (1 << b);
        end
        return code;
    endfunction

    // Write order: per row col W-1 then 0..W-2, rows 0..H-2, then last row ascending.
    task automatic build_seq();
        exp_seq.delete();
        for (int r = 1; r < H; r++) begin
            exp_seq.push_back((r-1) * W + W - 1);
            for (int c = 0; c < W-1; c++) exp_seq.push_back((r-1) * W + c);
        end
        for (int c = 0; c < W; c++) exp_seq.push_back((H-1) * W + c);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: img[i] = 50;
                1: img[i] = i;
                2: img[i] = 255;
                3: img[i] = int'($urandom_range(40, 60));
                default: img[i] = int'($urandom_range(0, 255));
            endcase
        end
        if (kind == 2) img[9] = 250;
    endtask

    // Monitor and responder: check on the falling edge, then drive the next inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (pend) acc_cnt++;
            if (mon_en) begin
                if (lbp_valid) begin
                    if (wi >= N) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_write: addr %0d after %0d writes", lbp_addr, wi);
                    end else begin
                        check("wr_addr", int'(lbp_addr), exp_seq[wi]);
                        check("wr_data", int'(lbp_data), model_code(int'(lbp_addr)));
                        if (wi < N - W) check("wr_follows_accept", int'(pend), 1);
                        got[lbp_addr] = int'(lbp_data);
                        if (wi < 4) first_addr[wi] = int'(lbp_addr);
                        wi++;
                    end
                end
                if (gray_req) check("gray_addr", int'(gray_addr), acc_cnt);
                if (finish) begin
                    fin_cnt++;
                    check("finish_after_all_writes", wi, N);
                    check("busy_in_done", int'(busy), 1);
                end
            end
            gray_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
            gray_data  = gray_req ? 8'(img[gray_addr]) : 8'h00;
            pend       = gray_req && gray_ready;
        end
    end

    task automatic kick(input int md, input int th, input int stp);
        m_mode    = md;
        m_thr     = th;
        stall_pct = stp;
        build_seq();
        for (int i = 0; i < N; i++) got[i] = -1;
        @(posedge clk);
        #2;
        wi      = 0;
        acc_cnt = 0;
        fin_cnt = 0;
        mon_en  = 1'b1;
        mode    = 1'(md);
        thr     = 8'(th);
        start   = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        mode  = ~mode;
        thr   = ~thr;
        check("req_after_start", int'(gray_req), 1);
        check("busy_after_start", int'(busy), 1);
        check("addr0_first_read", int'(gray_addr), 0);
    endtask

    task automatic run_frame(input int md, input int th, input int stp, input bit extra);
        int cyc;
        bit flush_pulsed;
        kick(md, th, stp);
        cyc = 0;
        flush_pulsed = 1'b0;
        while (fin_cnt == 0 && cyc < 2000) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            cyc++;
            if (extra && cyc == 5) start = 1'b1;
            if (extra && !flush_pulsed && busy && !gray_req && !finish) begin
                start = 1'b1;
                flush_pulsed = 1'b1;
            end
        end
        start = 1'b0;
        check("finish_seen", fin_cnt, 1);
        check("busy_falls_after_done", int'(busy), 0);
        check("finish_one_cycle", int'(finish), 0);
        repeat (3) @(posedge clk);
        #2;
        check("writes_total", wi, N);
        check("finish_pulses", fin_cnt, 1);
        check("req_idle", int'(gray_req), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gray_addr"}, int'(gray_addr), 0);
        check({tag, "_gray_req"},  int'(gray_req), 0);
        check({tag, "_lbp_addr"},  int'(lbp_addr), 0);
        check({tag, "_lbp_valid"}, int'(lbp_valid), 0);
        check({tag, "_lbp_data"},  int'(lbp_data), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_finish"},    int'(finish), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #2;

        // Uniform frame, standard mode.
        fill(0);
        m_mode = 0;
        check("model_uniform_interior", model_code(9), 255);
        check("model_uniform_border", model_code(8), 0);
        run_frame(0, 0, 0, 1'b0);
        check("uni_9", got[9], 255);
        check("uni_14", got[14], 255);
        check("uni_17", got[17], 255);
        check("uni_0", got[0], 0);
        check("uni_8", got[8], 0);
        check("uni_15", got[15], 0);
        check("uni_26", got[26], 0);
        check("order_0", first_addr[0], 7);
        check("order_1", first_addr[1], 0);
        check("order_2", first_addr[2], 1);
        check("order_3", first_addr[3], 2);

        // Ramp: right, bottom-left, bottom and bottom-right neighbours are larger.
        fill(1);
        m_mode = 0;
        check("model_ramp", model_code(9), 8'hF0);
        run_frame(0, 0, 0, 1'b0);
        check("ramp_9", got[9], 8'hF0);
        check("ramp_10", got[10], 8'hF0);
        check("ramp_22", got[22], 8'hF0);

        // Thresholded mode on a uniform frame.
        fill(0);
        run_frame(1, 1, 0, 1'b0);
        check("thr1_9", got[9], 0);
        run_frame(1, 0, 0, 1'b0);
        check("thr0_9", got[9], 255);

        // Centre 250 among 255s: thr 10 pushes the reference past 255.
        fill(2);
        m_mode = 1;
        m_thr  = 10;
        check("model_sat", model_code(9), 0);
        run_frame(1, 10, 0, 1'b0);
        check("sat_9", got[9], 0);
        run_frame(0, 0, 0, 1'b0);
        check("sat_mode0_9", got[9], 255);

        // Random frames with ~50% stalls.
        fill(3);
        run_frame(0, 0, 50, 1'b0);
        fill(4);
        run_frame(1, int'($urandom_range(0, 20)), 50, 1'b0);
        fill(3);
        run_frame(1, 3, 30, 1'b1);

        // Reset mid-READ, then a full frame.
        fill(4);
        kick(0, 0, 20);
        cyc = 0;
        while (acc_cnt < 20 && cyc < 500) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("abort_point_reached", int'(acc_cnt >= 20), 1);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", int'(lbp_valid), 0);
        #2;
        reset = 1'b1;
        fill(4);
        run_frame(0, 0, 50, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
